// File: rtl/e2_validate_vop_if.sv
// Handshake and memory-data bundle between the E2 result validator and its test harness.
interface e2_validate_vop_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned N      = 64,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ERR_W  = 8
);
  logic                 module_en;
  logic [1:0]           mode;
  logic                 busy;
  logic                 module_done;
  logic [ADDR_W-1:0]    index_compute;
  logic [ADDR_W-1:0]    index_ref1;
  logic [ADDR_W-1:0]    index_ref2;
  logic [LANES*N-1:0]   fixed_point_compute;
  logic [LANES*N-1:0]   fixed_point_ref1;
  logic [LANES*N-1:0]   fixed_point_ref2;
  logic                 error;
  logic [LANES-1:0]     error_lanes;
  logic [ERR_W-1:0]     error_num;
  logic                 first_err_valid;
  logic [ADDR_W-1:0]    first_err_index;

  modport master (
    output module_en, mode, fixed_point_compute, fixed_point_ref1, fixed_point_ref2,
    input  busy, module_done, index_compute, index_ref1, index_ref2,
           error, error_lanes, error_num, first_err_valid, first_err_index
  );

  modport slave (
    input  module_en, mode, fixed_point_compute, fixed_point_ref1, fixed_point_ref2,
    output busy, module_done, index_compute, index_ref1, index_ref2,
           error, error_lanes, error_num, first_err_valid, first_err_index
  );
endinterface

// File: rtl/e2_validate_vop.sv
// Streams result/operand words from memory, recomputes add/sub/Q-mul per lane and
// flags lanes whose signed difference exceeds the tolerance.
module e2_validate_vop #(
  parameter int unsigned      CATCH_NUM    = 100,
  parameter int unsigned      LANES        = 4,
  parameter int unsigned      N            = 64,
  parameter int unsigned      Q            = 15,
  parameter int unsigned      RD_LAT       = 1,
  parameter int unsigned      ADDR_W       = 8,
  parameter int unsigned      ERR_W        = 8,
  parameter logic [N-1:0]     TOL          = '0,
  parameter logic [ADDR_W-1:0] COMPUTE_BASE = '0,
  parameter logic [ADDR_W-1:0] REF1_BASE    = '0,
  parameter logic [ADDR_W-1:0] REF2_BASE    = ADDR_W'(CATCH_NUM)
) (
  input logic                clk,
  input logic                rst_n,
  e2_validate_vop_if.slave   bus
);

  localparam int unsigned CNT_W = (CATCH_NUM > 1) ? $clog2(CATCH_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CATCH_NUM - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e              r_state;
  logic [1:0]          r_mode;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_idx_c, r_idx_1, r_idx_2;
  logic                r_done;
  logic                r_err;
  logic [LANES-1:0]    r_err_lanes;
  logic [ERR_W-1:0]    r_err_num;
  logic                r_first_vld;
  logic [ADDR_W-1:0]   r_first_idx;

  logic                w_iss;
  logic                w_cmp_vld;
  logic [CNT_W-1:0]    w_cmp_off;
  logic [LANES-1:0]    w_bad;

  assign w_iss = (r_state == StIssue);

  // Tracks which issued offset the memory data currently belongs to.
  if (RD_LAT == 0) begin : g_lat0
    assign w_cmp_vld = w_iss;
    assign w_cmp_off = r_cnt;
  end else begin : g_lat
    logic [RD_LAT-1:0] r_vld;
    logic [CNT_W-1:0]  r_off [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= '0;
        for (int i = 0; i < int'(RD_LAT); i++) r_off[i] <= '0;
      end else begin
        r_vld[0] <= w_iss;
        r_off[0] <= r_cnt;
        for (int i = 1; i < int'(RD_LAT); i++) begin
          r_vld[i] <= r_vld[i-1];
          r_off[i] <= r_off[i-1];
        end
      end
    end

    assign w_cmp_vld = r_vld[RD_LAT-1];
    assign w_cmp_off = r_off[RD_LAT-1];
  end

  for (genvar gl = 0; gl < int'(LANES); gl++) begin : g_lane
    logic signed [N-1:0]   w_a, w_b, w_c, w_ref;
    logic signed [2*N-1:0] w_prod;
    logic        [N:0]     w_diff, w_mag;

    assign w_a    = bus.fixed_point_ref1[gl*N +: N];
    assign w_b    = bus.fixed_point_ref2[gl*N +: N];
    assign w_c    = bus.fixed_point_compute[gl*N +: N];
    assign w_prod = w_a * w_b;

    always_comb begin
      case (r_mode)
        2'b01:   w_ref = w_a - w_b;
        2'b10:   w_ref = N'(w_prod >>> Q);
        default: w_ref = w_a + w_b;
      endcase
    end

    // One extra bit keeps the difference exact before taking its magnitude.
    assign w_diff   = {w_c[N-1], w_c} - {w_ref[N-1], w_ref};
    assign w_mag    = w_diff[N] ? (~w_diff + 1'b1) : w_diff;
    assign w_bad[gl] = (w_mag > {1'b0, TOL});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_mode      <= 2'b00;
      r_cnt       <= '0;
      r_idx_c     <= COMPUTE_BASE;
      r_idx_1     <= REF1_BASE;
      r_idx_2     <= REF2_BASE;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_lanes <= '0;
      r_err_num   <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_cmp_vld) begin
        r_err_lanes <= w_bad;
        r_err       <= |w_bad;
        if (|w_bad) begin
          if (r_err_num != {ERR_W{1'b1}}) r_err_num <= r_err_num + ERR_W'(1);
          if (!r_first_vld) begin
            r_first_vld <= 1'b1;
            r_first_idx <= ADDR_W'(w_cmp_off);
          end
        end
      end

      case (r_state)
        StIdle: begin
          if (bus.module_en) begin
            r_state     <= StIssue;
            r_mode      <= bus.mode;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_err_lanes <= '0;
            r_err_num   <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
          end
        end
        StIssue: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_idx_c <= COMPUTE_BASE;
            r_idx_1 <= REF1_BASE;
            r_idx_2 <= REF2_BASE;
            // With zero latency the last word is compared in this very cycle.
            if (RD_LAT == 0) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end else begin
              r_state <= StDrain;
            end
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_idx_c <= r_idx_c + ADDR_W'(1);
            r_idx_1 <= r_idx_1 + ADDR_W'(1);
            r_idx_2 <= r_idx_2 + ADDR_W'(1);
          end
        end
        StDrain: begin
          if (w_cmp_vld && (w_cmp_off == LAST)) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy            = (r_state != StIdle);
  assign bus.module_done     = r_done;
  assign bus.index_compute   = r_idx_c;
  assign bus.index_ref1      = r_idx_1;
  assign bus.index_ref2      = r_idx_2;
  assign bus.error           = r_err;
  assign bus.error_lanes     = r_err_lanes;
  assign bus.error_num       = r_err_num;
  assign bus.first_err_valid = r_first_vld;
  assign bus.first_err_index = r_first_idx;

endmodule

// File: tb/tb_e2_validate_vop.sv
// Drives two validator instances (registered and combinational memory) from shared
// word data and checks every output each cycle against an arithmetic reference model.
module tb_e2_validate_vop;

  localparam int C  = 8;
  localparam int L  = 4;
  localparam int NB = 64;
  localparam int TQ = 15;

  localparam int          LAT [2] = '{1, 0};
  localparam logic [63:0] TOLV[2] = '{64'd0, 64'd1};
  localparam int          SAT [2] = '{3, 15};
  localparam int          CB  [2] = '{0, 252};
  localparam int          R1B [2] = '{0, 100};
  localparam int          R2B [2] = '{8, 200};

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [1:0] md;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  e2_validate_vop_if #(.LANES(L), .N(NB), .ADDR_W(8), .ERR_W(2)) bus0 ();
  e2_validate_vop_if #(.LANES(L), .N(NB), .ADDR_W(8), .ERR_W(4)) bus1 ();

  e2_validate_vop #(
    .CATCH_NUM(C), .LANES(L), .N(NB), .Q(TQ), .RD_LAT(1), .ADDR_W(8), .ERR_W(2),
    .TOL(64'd0), .COMPUTE_BASE(8'd0), .REF1_BASE(8'd0), .REF2_BASE(8'd8)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  e2_validate_vop #(
    .CATCH_NUM(C), .LANES(L), .N(NB), .Q(TQ), .RD_LAT(0), .ADDR_W(8), .ERR_W(4),
    .TOL(64'd1), .COMPUTE_BASE(8'd252), .REF1_BASE(8'd100), .REF2_BASE(8'd200)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [L*NB-1:0] mem_c [2][256];
  logic [L*NB-1:0] mem_1 [2][256];
  logic [L*NB-1:0] mem_2 [2][256];
  logic [L*NB-1:0] rd_c, rd_1, rd_2;

  always @(posedge clk) begin
    rd_c <= mem_c[0][bus0.index_compute];
    rd_1 <= mem_1[0][bus0.index_ref1];
    rd_2 <= mem_2[0][bus0.index_ref2];
  end

  assign bus0.module_en           = en;
  assign bus0.mode                = md;
  assign bus0.fixed_point_compute = rd_c;
  assign bus0.fixed_point_ref1    = rd_1;
  assign bus0.fixed_point_ref2    = rd_2;
  assign bus1.module_en           = en;
  assign bus1.mode                = md;
  assign bus1.fixed_point_compute = mem_c[1][bus1.index_compute];
  assign bus1.fixed_point_ref1    = mem_1[1][bus1.index_ref1];
  assign bus1.fixed_point_ref2    = mem_2[1][bus1.index_ref2];

  logic [63:0] w_r1 [C][L];
  logic [63:0] w_r2 [C][L];
  logic [63:0] w_c  [C][L];

  typedef struct {
    logic busy, done, err, fv;
    logic [L-1:0] lanes;
    logic [7:0] num, fi, ic, i1, i2;
  } obs_t;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample(input int d);
    obs_t o;
    if (d == 0) begin
      o.busy = bus0.busy; o.done = bus0.module_done; o.err = bus0.error;
      o.fv = bus0.first_err_valid; o.lanes = bus0.error_lanes; o.num = 8'(bus0.error_num);
      o.fi = bus0.first_err_index; o.ic = bus0.index_compute; o.i1 = bus0.index_ref1;
      o.i2 = bus0.index_ref2;
    end else begin
      o.busy = bus1.busy; o.done = bus1.module_done; o.err = bus1.error;
      o.fv = bus1.first_err_valid; o.lanes = bus1.error_lanes; o.num = 8'(bus1.error_num);
      o.fi = bus1.first_err_index; o.ic = bus1.index_compute; o.i1 = bus1.index_ref1;
      o.i2 = bus1.index_ref2;
    end
    return o;
  endfunction

  function automatic logic signed [127:0] sx(input logic [63:0] v);
    return $signed({{64{v[63]}}, v});
  endfunction

  // Reference lane result from plain integer arithmetic; mul uses floor division.
  function automatic logic [63:0] ref_lane(input logic [1:0] m, input logic [63:0] a,
                                           input logic [63:0] b);
    logic signed [127:0] p, s;
    s = 128'sd1 <<< TQ;
    case (m)
      2'b01: p = sx(a) - sx(b);
      2'b10: begin
        p = sx(a) * sx(b);
        if (p >= 0) p = p / s;
        else        p = -((-p + s - 128'sd1) / s);
      end
      default: p = sx(a) + sx(b);
    endcase
    return p[63:0];
  endfunction

  function automatic logic [L-1:0] word_flags(input int k, input logic [1:0] m,
                                              input logic [63:0] tol);
    logic [L-1:0] f;
    logic signed [127:0] dv;
    for (int l = 0; l < L; l++) begin
      dv = sx(w_c[k][l]) - sx(ref_lane(m, w_r1[k][l], w_r2[k][l]));
      if (dv < 0) dv = -dv;
      f[l] = (dv > $signed({64'd0, tol}));
    end
    return f;
  endfunction

  // kind 0: clean, 1: sparse random corruption, 2: every word corrupted
  task automatic gen(input logic [1:0] m, input int kind);
    logic [63:0] dl;
    for (int k = 0; k < C; k++) begin
      for (int l = 0; l < L; l++) begin
        w_r1[k][l] = {$urandom(), $urandom()};
        w_r2[k][l] = {$urandom(), $urandom()};
        w_c[k][l]  = ref_lane(m, w_r1[k][l], w_r2[k][l]);
        if (kind == 1 && $urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 4))
            0: dl = 64'd1;
            1: dl = 64'd2;
            2: dl = -64'd1;
            3: dl = -64'd2;
            default: dl = {$urandom(), $urandom()};
          endcase
          w_c[k][l] = w_c[k][l] + dl;
        end
      end
      if (kind == 2) w_c[k][$urandom_range(0, L-1)] += 64'd5;
    end
  endtask

  task automatic load();
    logic [L*NB-1:0] vc, v1, v2;
    for (int k = 0; k < C; k++) begin
      for (int l = 0; l < L; l++) begin
        vc[l*NB +: NB] = w_c[k][l];
        v1[l*NB +: NB] = w_r1[k][l];
        v2[l*NB +: NB] = w_r2[k][l];
      end
      for (int d = 0; d < 2; d++) begin
        mem_c[d][(CB[d] + k) % 256] = vc;
        mem_1[d][(R1B[d] + k) % 256] = v1;
        mem_2[d][(R2B[d] + k) % 256] = v2;
      end
    end
  endtask

  task automatic check_idle_reset(input string tg);
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      o = sample(d);
      check_eq($sformatf("%s d%0d busy", tg, d), 64'(o.busy), 64'd0);
      check_eq($sformatf("%s d%0d done", tg, d), 64'(o.done), 64'd0);
      check_eq($sformatf("%s d%0d error", tg, d), 64'(o.err), 64'd0);
      check_eq($sformatf("%s d%0d lanes", tg, d), 64'(o.lanes), 64'd0);
      check_eq($sformatf("%s d%0d num", tg, d), 64'(o.num), 64'd0);
      check_eq($sformatf("%s d%0d fv", tg, d), 64'(o.fv), 64'd0);
      check_eq($sformatf("%s d%0d idx_c", tg, d), 64'(o.ic), 64'(CB[d]));
      check_eq($sformatf("%s d%0d idx_2", tg, d), 64'(o.i2), 64'(R2B[d]));
    end
  endtask

  // Starts a run at the current negedge and checks every output through cycle C+3.
  task automatic run_once(input logic [1:0] m, input int en_at);
    logic [L-1:0] fl [2][C];
    logic [L-1:0] elan;
    int j, last, ecnt, efi;
    bit efv;
    obs_t o;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < C; k++) fl[d][k] = word_flags(k, m, TOLV[d]);
    en = 1'b1;
    md = m;
    @(negedge clk);
    md = 2'($urandom_range(0, 3));
    for (int t = 0; t <= C + 3; t++) begin
      en = (t == en_at);
      for (int d = 0; d < 2; d++) begin
        o = sample(d);
        j = t - LAT[d] - 1;
        last = (j < C) ? j : C - 1;
        elan = (j < 0) ? '0 : fl[d][last];
        ecnt = 0; efv = 0; efi = 0;
        for (int k = 0; k <= last; k++) begin
          if (fl[d][k] != 0) begin
            if (!efv) begin efv = 1; efi = k; end
            ecnt++;
          end
        end
        if (ecnt > SAT[d]) ecnt = SAT[d];
        check_eq($sformatf("m%0d d%0d t%0d busy", m, d, t), 64'(o.busy), 64'(t < C + LAT[d]));
        check_eq($sformatf("m%0d d%0d t%0d done", m, d, t), 64'(o.done), 64'(t == C + LAT[d]));
        check_eq($sformatf("m%0d d%0d t%0d lanes", m, d, t), 64'(o.lanes), 64'(elan));
        check_eq($sformatf("m%0d d%0d t%0d error", m, d, t), 64'(o.err), 64'(elan != 0));
        check_eq($sformatf("m%0d d%0d t%0d num", m, d, t), 64'(o.num), 64'(ecnt));
        check_eq($sformatf("m%0d d%0d t%0d fv", m, d, t), 64'(o.fv), 64'(efv));
        check_eq($sformatf("m%0d d%0d t%0d fi", m, d, t), 64'(o.fi), 64'(efi));
        check_eq($sformatf("m%0d d%0d t%0d idx_c", m, d, t), 64'(o.ic),
                 64'((CB[d] + (t < C ? t : 0)) % 256));
        check_eq($sformatf("m%0d d%0d t%0d idx_1", m, d, t), 64'(o.i1),
                 64'((R1B[d] + (t < C ? t : 0)) % 256));
        check_eq($sformatf("m%0d d%0d t%0d idx_2", m, d, t), 64'(o.i2),
                 64'((R2B[d] + (t < C ? t : 0)) % 256));
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic abort_run();
    obs_t o;
    gen(2'b00, 2);
    load();
    en = 1'b1;
    md = 2'b00;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_reset("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < C + 4; t++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        o = sample(d);
        check_eq($sformatf("abort d%0d t%0d done", d, t), 64'(o.done), 64'd0);
        check_eq($sformatf("abort d%0d t%0d busy", d, t), 64'(o.busy), 64'd0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    md    = 2'b00;
    repeat (3) @(negedge clk);
    check_idle_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    gen(2'b00, 0); load(); run_once(2'b00, -1);

    gen(2'b01, 0);
    w_c[5][2] += 64'd1;
    w_c[3][0] += 64'd2;
    load(); run_once(2'b01, -1);

    gen(2'b10, 1);
    w_r1[0][0] = 64'h8000; w_r2[0][0] = 64'hFFFF_FFFF_FFFF_C000;
    w_c[0][0]  = 64'hFFFF_FFFF_FFFF_C000;
    w_r1[2][0] = 64'h8000; w_r2[2][0] = 64'hFFFF_FFFF_FFFF_C000;
    w_c[2][0]  = 64'hFFFF_FFFF_FFFF_C001;
    load(); run_once(2'b10, -1);

    gen(2'b00, 2); load(); run_once(2'b00, -1);
    gen(2'b01, 1); load(); run_once(2'b01, 3);
    gen(2'b11, 1); load(); run_once(2'b11, -1);

    abort_run();
    gen(2'b01, 1); load(); run_once(2'b01, -1);

    for (int r = 0; r < 6; r++) begin
      md = 2'($urandom_range(0, 3));
      gen(md, 1 + (r % 2));
      load();
      run_once(md, (r == 2) ? 5 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
